// File: rtl/array_req_ctrl.sv
// Request controller for a 64x114 single-port array: zero-fills the array after
// reset, then issues ordered masked writes and reads with a 2-entry response FIFO.
module array_req_ctrl (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [5:0]     req_addr,
  input  logic [1:0]     req_wmask,
  input  logic [113:0]   req_wdata,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [113:0]   resp_data,
  output logic           mem_en,
  output logic           mem_wmode,
  output logic [5:0]     mem_addr,
  output logic [1:0]     mem_wmask,
  output logic [113:0]   mem_wdata,
  input  logic [113:0]   mem_rdata,
  output logic           init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t         state;
  logic [5:0]     init_cnt;
  logic           inflight;
  logic [1:0]     occ;
  logic [113:0]   slot0;
  logic [113:0]   slot1;
  logic           pop;
  logic           push;
  logic           rd_ok;
  logic           fire;
  logic [2:0]     pend;

  assign pop        = resp_valid && resp_ready;
  assign push       = inflight;
  assign resp_valid = occ != 2'd0;
  assign resp_data  = slot0;

  // pop implies occ>=1, so this never underflows
  assign pend  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_ok = pend < 3'd2;

  assign req_ready = (state == RUN) && (req_write || rd_ok);
  assign fire      = req_valid && req_ready;

  // reset_n gates the fill so the array sees no enable while held in reset
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_en    = reset_n;
      mem_wmode = reset_n;
      mem_addr  = init_cnt;
      mem_wmask = {2{reset_n}};
    end else if (fire) begin
      mem_en    = 1'b1;
      mem_wmode = req_write;
      mem_addr  = req_addr;
      mem_wmask = req_wmask;
      mem_wdata = req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      inflight  <= 1'b0;
      occ       <= '0;
    end else begin
      inflight <= (state == RUN) && fire && !req_write;
      if (state == INIT) begin
        init_cnt <= init_cnt + 6'd1;
        if (init_cnt == 6'd63) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      if (push && occ == 2'd1) slot0 <= mem_rdata;
      else                     slot0 <= slot1;
      if (push && occ == 2'd2) slot1 <= mem_rdata;
    end else if (push) begin
      if (occ == 2'd0) slot0 <= mem_rdata;
      else             slot1 <= mem_rdata;
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && occ == 2'd2 && !pop));

endmodule

// File: tb/tb_array_req_ctrl.sv
// Bench for array_req_ctrl: behavioural array, timestamped response model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_array_req_ctrl;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid, req_ready, req_write;
  logic [5:0]   req_addr;
  logic [1:0]   req_wmask;
  logic [113:0] req_wdata;
  logic         resp_valid, resp_ready;
  logic [113:0] resp_data;
  logic         mem_en, mem_wmode;
  logic [5:0]   mem_addr;
  logic [1:0]   mem_wmask;
  logic [113:0] mem_wdata;
  logic [113:0] mem_rdata;
  logic         init_done;

  array_req_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chkd(input string nm, input logic [113:0] a,
                      input logic [113:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // behavioural single-port array, seeded with garbage so the fill matters
  logic [113:0] arr [64];
  bit seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++)
        arr[i] <= 114'({$urandom, $urandom, $urandom, $urandom});
      seeded <= 1'b1;
    end else if (mem_en) begin
      if (mem_wmode) begin
        if (mem_wmask[0]) arr[mem_addr][56:0]   <= mem_wdata[56:0];
        if (mem_wmask[1]) arr[mem_addr][113:57] <= mem_wdata[113:57];
      end else begin
        mem_rdata <= arr[mem_addr];
      end
    end
  end

  // model: contents as seen in acceptance order, responses due 2 cycles later
  typedef struct {
    logic [113:0] d;
    int           due;
  } ent_t;

  ent_t         q[$];
  logic [113:0] got[$];
  logic [113:0] shadow [64];
  bit           m_init = 1'b1;
  int           icnt = 0;
  int           cyc = 0;

  always @(negedge clock) begin
    bit exp_rv, exp_rdy, acc;
    int pop;
    if (!reset_n) begin
      m_init = 1'b1;
      icnt = 0;
      q.delete();
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_init_done", init_done, 1'b0);
    end else if (m_init) begin
      cyc++;
      chk1("init_mem_en", mem_en, 1'b1);
      chk1("init_wmode", mem_wmode, 1'b1);
      chkd("init_addr", 114'(mem_addr), 114'(icnt));
      chkd("init_wmask", 114'(mem_wmask), 114'd3);
      chkd("init_wdata", mem_wdata, '0);
      chk1("init_req_ready", req_ready, 1'b0);
      chk1("init_resp_valid", resp_valid, 1'b0);
      chk1("init_done_low", init_done, 1'b0);
      shadow[icnt] = '0;
      icnt++;
      if (icnt == 64) m_init = 1'b0;
    end else begin
      cyc++;
      chk1("run_init_done", init_done, 1'b1);
      exp_rv = q.size() > 0 && q[0].due <= cyc;
      chk1("resp_valid", resp_valid, exp_rv);
      if (exp_rv) chkd("resp_data", resp_data, q[0].d);
      pop = (exp_rv && resp_ready) ? 1 : 0;
      exp_rdy = req_write ? 1'b1 : ((q.size() - pop) < 2);
      chk1("req_ready", req_ready, exp_rdy);
      acc = req_valid && exp_rdy;
      chk1("mem_en", mem_en, acc);
      if (acc) begin
        chk1("mem_wmode", mem_wmode, req_write);
        chkd("mem_addr", 114'(mem_addr), 114'(req_addr));
        chkd("mem_wmask", 114'(mem_wmask), 114'(req_wmask));
        chkd("mem_wdata", mem_wdata, req_wdata);
      end else begin
        chkd("mem_idle", {mem_wdata[111:0], mem_wmask},
             '0);
        chkd("mem_idle2", 114'({mem_wmode, mem_addr,
             mem_wdata[113:112]}), '0);
      end
      if (resp_valid && resp_ready) got.push_back(resp_data);
      if (pop == 1) void'(q.pop_front());
      if (acc) begin
        if (req_write) begin
          if (req_wmask[0]) shadow[req_addr][56:0]   = req_wdata[56:0];
          if (req_wmask[1]) shadow[req_addr][113:57] = req_wdata[113:57];
        end else begin
          q.push_back('{d: shadow[req_addr], due: cyc + 2});
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [5:0] a,
                        input logic [1:0] m, input logic [113:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("req_accept_bound", ok, 1'b1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic wait_got(input int target);
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (got.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #2;
    end
    chk1("resp_bound", ok, 1'b1);
  endtask

  task automatic read_one(input logic [5:0] a, output logic [113:0] d);
    int n0 = got.size();
    do_req(1'b0, a, 2'b00, '0);
    wait_got(n0 + 1);
    d = (got.size() > n0) ? got[n0] : '0;
  endtask

  task automatic wait_init(output int nw);
    nw = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (init_done) break;
      if (mem_en) nw++;
    end
    chk1("init_done_rise", init_done, 1'b1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [113:0] d;
    logic [113:0] lane0;
    int nw, acc, n0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    lane0 = (114'd1 << 57) - 114'd1;

    repeat (3) @(posedge clock);
    #1;
    chk1("reset_mem_en", mem_en, 1'b0);
    chk1("reset_done", init_done, 1'b0);
    reset_n = 1'b1;
    wait_init(nw);
    chki("init_write_count", nw, 64);

    read_one(6'd37, d);
    chkd("read37_zero", d, '0);

    do_req(1'b1, 6'd5, 2'b01, {114{1'b1}});
    read_one(6'd5, d);
    chkd("lane0_only", d, lane0);

    for (int i = 0; i < 10; i++)
      do_req(1'b1, 6'(i), 2'b11, 114'(100 + i));

    n0 = got.size();
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_addr = 6'(i);
      @(negedge clock);
      chk1("b2b_ready", req_ready, 1'b1);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    wait_got(n0 + 10);
    for (int i = 0; i < 10; i++)
      if (got.size() > n0 + i)
        chkd("b2b_data", got[n0 + i], 114'(100 + i));

    n0 = got.size();
    resp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_addr = 6'd0;
    repeat (6) begin
      @(negedge clock);
      if (req_ready) acc++;
      @(posedge clock);
      #1;
      req_addr = 6'(acc);
    end
    chki("stall_accepts", acc, 2);
    @(negedge clock);
    chk1("stall_ready", req_ready, 1'b0);
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    for (int n = 0; n < 20 && acc < 4; n++) begin
      @(negedge clock);
      if (req_ready) acc++;
      @(posedge clock);
      #1;
      req_addr = 6'(acc);
    end
    req_valid = 1'b0;
    chki("stall_total", acc, 4);
    wait_got(n0 + 4);
    for (int i = 0; i < 4; i++)
      if (got.size() > n0 + i)
        chkd("stall_order", got[n0 + i], 114'(100 + i));

    do_req(1'b1, 6'd9, 2'b11, 114'hA);
    n0 = got.size();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'd9;
    @(negedge clock);
    chk1("raw_rd_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_write = 1'b1;
    req_wmask = 2'b11;
    req_wdata = 114'hB;
    @(negedge clock);
    chk1("raw_wr_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    wait_got(n0 + 1);
    if (got.size() > n0) chkd("read_before_write", got[n0], 114'hA);
    read_one(6'd9, d);
    chkd("read_after_write", d, 114'hB);

    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 6'd1;
    @(negedge clock);
    chk1("rst_rd1_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_addr = 6'd2;
    @(negedge clock);
    chk1("rst_rd2_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk1("pre_reset_valid", resp_valid, 1'b1);
    n0 = got.size();
    reset_n = 1'b0;
    #1;
    chk1("async_resp_valid", resp_valid, 1'b0);
    chk1("async_req_ready", req_ready, 1'b0);
    chk1("async_mem_en", mem_en, 1'b0);
    chk1("async_init_done", init_done, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    resp_ready = 1'b1;
    reset_n = 1'b1;
    wait_init(nw);
    chki("reinit_write_count", nw, 64);
    repeat (5) @(posedge clock);
    #2;
    chki("no_stale_resp", got.size(), n0);
    read_one(6'd3, d);
    chkd("refill_zero", d, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_req_ctrl.md
ARRAY_REQ_CTRL -- requirements
Module: array_req_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 `clock  in  1  rising-edge clock for all state`
REQ-003 `reset_n  in  1  asynchronous active-low reset`
REQ-004 `req_valid  in  1  request valid`
REQ-005 `req_ready  out  1  request accepted when req_valid && req_ready`
REQ-006 `req_write  in  1  1 = masked write, 0 = read`
REQ-007 `req_addr  in  6  entry index 0..63`
REQ-008 `req_wmask  in  2  lane enables: bit0 = data[56:0], bit1 = data[113:57]`
REQ-009 `req_wdata  in  114  write data`
REQ-010 `resp_valid  out  1  read response valid`
REQ-011 `resp_ready  in  1  response consumed when resp_valid && resp_ready`
REQ-012 `resp_data  out  114  read data, in request order`
REQ-013 `mem_en / mem_wmode / mem_addr[5:0] / mem_wmask[1:0] / mem_wdata[113:0]  out  drive of a 64x114 single-port array`
REQ-014 `mem_rdata  in  114  array read data, valid exactly one cycle after a read enable`
REQ-015 `init_done  out  1  high once the post-reset zero-fill is complete`

Function
REQ-016 The block SHALL implement two states: INIT and RUN.
REQ-017 INIT SHALL drive one write per cycle with wmode=1, wmask=2'b11, wdata=0, addr=init_cnt, then increment init_cnt; init_cnt is 6 bits and starts at 0.
REQ-018 The block SHALL go INIT->RUN in the cycle after the write to addr 63 (64 INIT cycles in total), and SHALL set init_done=1 on entering RUN.
REQ-019 req_ready SHALL be 0 in INIT.
REQ-020 In RUN, mem_en SHALL equal req_valid && req_ready, combinationally.
- mem_wmode, mem_addr, mem_wmask and mem_wdata SHALL pass through from req_*.
- When mem_en=0, all mem_* outputs SHALL be 0.
REQ-021 Write ready SHALL be 1 in RUN. Writes SHALL produce no response.
REQ-022 Read ready in RUN SHALL be 1 only when occ + inflight − pop < 2.
- occ: response FIFO occupancy, 0..2.
- inflight: 1 if a read was issued in the previous cycle.
- pop: resp_valid && resp_ready.
REQ-023 A read accepted in cycle t SHALL set inflight for cycle t+1; mem_rdata SHALL be pushed into the FIFO at the end of cycle t+1.
- resp_valid is first visible in cycle t+2 (latency 2, no bypass).
REQ-024 The response FIFO SHALL be 2 entries deep.
- resp_valid = occ!=0; resp_data = FIFO head.
- Simultaneous push and pop SHALL leave occ unchanged and preserve order.
REQ-025 The FIFO SHALL never overflow; REQ-022 guarantees a slot for every in-flight read.
- Push when occ==2 without a pop is an assertion failure.
REQ-026 With resp_ready held at 1, back-to-back reads SHALL be accepted every cycle (throughput 1/cycle).
REQ-027 A write accepted in cycle t+1 to the same address as a read accepted in t SHALL NOT affect that read's data; the read returns the pre-write value.
REQ-028 Reads and writes SHALL be issued in acceptance order; a write accepted before a read to the same address SHALL be visible to that read.
REQ-029 resp_data SHALL be held stable while resp_valid && !resp_ready.

Reset
REQ-030 When reset_n=0, the block SHALL asynchronously force:
- state=INIT, init_cnt=0, init_done=0, inflight=0, occ=0;
- req_ready=0, resp_valid=0, mem_en=0.
REQ-031 On release of reset_n, the zero-fill SHALL restart from addr 0.
REQ-032 Reset in mid-RUN SHALL discard in-flight reads and buffered responses; no response SHALL appear after reset for pre-reset requests.
REQ-033 resp_data and the FIFO storage need no reset value.

Verification
REQ-034 Release reset, hold req_valid=0 -> exactly 64 cycles of mem_en=1, wmode=1, wmask=3, addr 0..63; init_done rises in the next cycle; a read of addr 37 afterwards returns 0.
REQ-035 Write addr 5, data 0x3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, wmask=2'b01 -> a read of addr 5 returns bits[56:0] all 1 and bits[113:57]=0.
REQ-036 Reads to addr 0..9 back-to-back with resp_ready=1 -> req_ready stays 1, one response per cycle from cycle t+2, data in order.
REQ-037 resp_ready=0, issue 4 reads -> 2 are accepted, req_ready=0 thereafter; raise resp_ready -> both responses are delivered in order, then the remaining reads are accepted.
REQ-038 Read addr 9 (holds 0xA), then in the next cycle write addr 9 = 0xB -> the response is 0xA; a following read returns 0xB.
REQ-039 Assert reset_n=0 with 1 read in flight and 1 response buffered -> resp_valid=0 immediately; after release, INIT reruns and no stale response appears.
